mul_seq_ctrl: RTL and testbench

Hardware sequencer for the program-3 workload: 16 signed 16-bit × 16-bit multiplies with 32-bit products, computed directly on data memory. Holds data memory's byte port for the whole run, so no instruction stream is involved. Behind the `top_level` start/done handshake:
- fetches each big-endian operand pair;
- runs a 16-iteration shift-add signed multiplier;
- writes each product back big-endian.

---
 rtl/mul_seq_ctrl_if.sv | 36 +++
 rtl/mul_seq_ctrl.sv | 164 ++++++++++++++++
 tb/tb_mul_seq_ctrl.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mul_seq_ctrl_if.sv
// Purpose: start/done handshake and byte-wide data-memory port of the multiply sequencer.
// Latency: wires only; no storage.
// Backpressure: none; memory reads are combinational and writes land on the rising edge.
interface mul_seq_ctrl_if #(
    parameter int AW = 8
);
    logic          start;
    logic          done;
    logic          busy;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_rd_data;
    logic          mem_wr_en;
    logic [7:0]    mem_wr_data;

    // Controller side.
    modport master (
        input  start,
        input  mem_rd_data,
        output done,
        output busy,
        output mem_addr,
        output mem_wr_en,
        output mem_wr_data
    );

    // Host / memory side.
    modport slave (
        output start,
        output mem_rd_data,
        input  done,
        input  busy,
        input  mem_addr,
        input  mem_wr_en,
        input  mem_wr_data
    );
endinterface

// File: rtl/mul_seq_ctrl.sv
// Purpose: runs NUM_PAIRS signed 16x16 shift-add multiplies straight out of byte memory (big-endian in and out).
// Latency: 24 cycles per pair (4 load, 16 multiply, 4 store); zero-operand pairs take 9 when MUL_ZERO_SKIP_EN is defined.
// Backpressure: none toward memory; start=1 during a run aborts to ARM, start high then low launches a run.
module mul_seq_ctrl #(
    parameter int NUM_PAIRS = 16,
    parameter int SRC_BASE  = 0,
    parameter int DST_BASE  = 64,
    parameter int AW        = 8
) (
    input  logic           clk,
    input  logic           reset,
    mul_seq_ctrl_if.master bus
);
    localparam int KW = (NUM_PAIRS > 1) ? $clog2(NUM_PAIRS) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_LOAD,
        S_MUL,
        S_STORE,
        S_DONE
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [KW-1:0] k;
    logic [3:0]    cnt;
    logic [15:0]   a;
    logic [15:0]   b;
    logic [31:0]   acc;
    logic [31:0]   acc_nxt;
    logic [31:0]   acc_base;
    logic [31:0]   a_sh;
    logic          done_q;
    logic          skip_now;
    logic          last_pair;
    logic          abort;

    assign last_pair = (k == KW'(NUM_PAIRS - 1));
    assign abort     = bus.start;

`ifdef MUL_ZERO_SKIP_EN
    logic zero_skip;

    // On the last load byte, decide whether this pair's multiply can be bypassed.
    always_ff @(posedge clk) begin
        if (reset) begin
            zero_skip <= 1'b0;
        end else if (state == S_LOAD && cnt == 4'd3) begin
            zero_skip <= (a == 16'd0) || ({b[15:8], bus.mem_rd_data} == 16'd0);
        end
    end

    assign skip_now = zero_skip && (cnt == 4'd0);
`else
    assign skip_now = 1'b0;
`endif

    // One shift-add step: bit 15 of B carries negative weight, so the last step subtracts.
    always_comb begin
        a_sh     = {{16{a[15]}}, a} << cnt;
        acc_base = (cnt == 4'd0) ? 32'd0 : acc;
        acc_nxt  = acc_base;
        if (skip_now) begin
            acc_nxt = 32'd0;
        end else if (b[cnt]) begin
            acc_nxt = (cnt == 4'd15) ? (acc_base - a_sh) : (acc_base + a_sh);
        end
    end

    // State register; reset wins over everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and memory-port outputs; the write strobe is blanked during reset.
    always_comb begin
        state_nxt       = state;
        bus.mem_addr    = '0;
        bus.mem_wr_en   = 1'b0;
        bus.mem_wr_data = 8'd0;
        case (state)
            S_IDLE: begin
                if (bus.start) state_nxt = S_ARM;
            end
            S_ARM: begin
                if (!bus.start) state_nxt = S_LOAD;
            end
            S_LOAD: begin
                bus.mem_addr = AW'(SRC_BASE) + AW'({k, cnt[1:0]});
                if (abort)              state_nxt = S_ARM;
                else if (cnt == 4'd3)   state_nxt = S_MUL;
            end
            S_MUL: begin
                if (abort)                          state_nxt = S_ARM;
                else if (skip_now || cnt == 4'd15)  state_nxt = S_STORE;
            end
            S_STORE: begin
                bus.mem_addr  = AW'(DST_BASE) + AW'({k, cnt[1:0]});
                bus.mem_wr_en = !reset;
                if (!reset) begin
                    case (cnt[1:0])
                        2'd0:    bus.mem_wr_data = acc[31:24];
                        2'd1:    bus.mem_wr_data = acc[23:16];
                        2'd2:    bus.mem_wr_data = acc[15:8];
                        default: bus.mem_wr_data = acc[7:0];
                    endcase
                end
                if (abort)              state_nxt = S_ARM;
                else if (cnt == 4'd3)   state_nxt = last_pair ? S_DONE : S_LOAD;
            end
            S_DONE: begin
                if (bus.start) state_nxt = S_ARM;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Datapath: pair index, step counter, operand latches, accumulator and registered done.
    always_ff @(posedge clk) begin
        if (reset) begin
            k      <= '0;
            cnt    <= 4'd0;
            a      <= 16'd0;
            b      <= 16'd0;
            acc    <= 32'd0;
            done_q <= 1'b0;
        end else begin
            done_q <= (state_nxt == S_DONE);
            case (state)
                S_ARM: begin
                    k   <= '0;
                    cnt <= 4'd0;
                end
                S_LOAD: begin
                    case (cnt[1:0])
                        2'd0:    a[15:8] <= bus.mem_rd_data;
                        2'd1:    a[7:0]  <= bus.mem_rd_data;
                        2'd2:    b[15:8] <= bus.mem_rd_data;
                        default: b[7:0]  <= bus.mem_rd_data;
                    endcase
                    cnt <= (cnt == 4'd3) ? 4'd0 : cnt + 4'd1;
                end
                S_MUL: begin
                    acc <= acc_nxt;
                    cnt <= skip_now ? 4'd0 : cnt + 4'd1;
                end
                S_STORE: begin
                    cnt <= (cnt == 4'd3) ? 4'd0 : cnt + 4'd1;
                    if (cnt == 4'd3 && !last_pair) k <= k + KW'(1);
                end
                default: ;
            endcase
        end
    end

    assign bus.done = done_q;
    assign bus.busy = (state == S_LOAD) || (state == S_MUL) || (state == S_STORE);
endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Purpose: randomized scoreboard bench for mul_seq_ctrl against a plain-arithmetic product model.
// Latency: checks done timing per run; memory writes are checked in order as the DUT issues them.
// Backpressure: none; covers abort, mid-store reset, start-during-reset and rerun handshakes.
module tb_mul_seq_ctrl;
    localparam int NP  = 16;
    localparam int SRC = 0;
    localparam int DST = 64;
    localparam int AW  = 8;

    typedef struct packed {
        logic [7:0] addr;
        logic [7:0] data;
    } wr_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    mul_seq_ctrl_if #(.AW(AW)) bus ();

    mul_seq_ctrl #(
        .NUM_PAIRS(NP),
        .SRC_BASE (SRC),
        .DST_BASE (DST),
        .AW       (AW)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    logic [7:0]        src_mem [256];
    logic [7:0]        dst_mem [256];
    logic [7:0]        snap    [256];
    logic signed [15:0] opa [NP];
    logic signed [15:0] opb [NP];
    wr_t               exp_q [$];
    int                errors = 0;
    int                checks = 0;

    assign bus.mem_rd_data = src_mem[bus.mem_addr];

    // Destination memory: only the DUT writes here.
    always @(posedge clk) begin
        if (bus.mem_wr_en) dst_mem[bus.mem_addr] <= bus.mem_wr_data;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Monitor: every write strobe must match the next expected byte.
    always @(negedge clk) begin
        wr_t e;
        if (!reset && bus.mem_wr_en) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got addr %0h data %0h expected no write", bus.mem_addr, bus.mem_wr_data);
            end else begin
                e = exp_q.pop_front();
                chk("wr_addr", 32'(bus.mem_addr), 32'(e.addr));
                chk("wr_data", 32'(bus.mem_wr_data), 32'(e.data));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // mode 0: A=3,B=5; 1: sign corners + zero pair + random; 2: random with zeros; 3: random nonzero
    task automatic prep(input int mode);
        for (int k = 0; k < NP; k++) begin
            opa[k] = 16'($urandom);
            opb[k] = 16'($urandom);
            if (mode == 0) begin
                opa[k] = 16'sd3;
                opb[k] = 16'sd5;
            end else if (mode == 2) begin
                if ($urandom_range(0, 3) == 0) opa[k] = 16'sd0;
                if ($urandom_range(0, 3) == 0) opb[k] = 16'sd0;
            end else if (mode == 3) begin
                if (opa[k] == 0) opa[k] = 16'sd1;
                if (opb[k] == 0) opb[k] = -16'sd7;
            end
        end
        if (mode == 1) begin
            opa[0] = 16'h8000; opb[0] = 16'h8000;
            opa[1] = 16'h8000; opb[1] = 16'h7FFF;
            opa[2] = 16'hFFFF; opb[2] = 16'hFFFF;
            opa[3] = 16'h7FFF; opb[3] = 16'h7FFF;
            opa[4] = 16'h0000; opb[4] = -16'sd12345;
        end
        for (int k = 0; k < NP; k++) begin
            src_mem[SRC + 4*k]     = opa[k][15:8];
            src_mem[SRC + 4*k + 1] = opa[k][7:0];
            src_mem[SRC + 4*k + 2] = opb[k][15:8];
            src_mem[SRC + 4*k + 3] = opb[k][7:0];
        end
    endtask

    task automatic push_pairs(input int first, input int last);
        for (int k = first; k <= last; k++) begin
            logic [31:0] pv;
            pv = 32'(int'(opa[k]) * int'(opb[k]));
            for (int j = 0; j < 4; j++) begin
                exp_q.push_back({8'(DST + 4*k + j), pv[31 - 8*j -: 8]});
            end
        end
    endtask

    function automatic int exp_cycles();
        int n = 1;
        for (int k = 0; k < NP; k++) begin
`ifdef MUL_ZERO_SKIP_EN
            n += (opa[k] == 0 || opb[k] == 0) ? 9 : 24;
`else
            n += 24;
`endif
        end
        return n;
    endfunction

    task automatic wait_done(input string nm, input int exp_n);
        int n = 0;
        do begin
            step();
            n++;
        end while (!bus.done && n < 3000);
        chk({nm, "_done_cycle"}, 32'(n), 32'(exp_n));
        chk({nm, "_queue_drained"}, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic launch(input string nm);
        bus.start = 1'b1;
        step();
        chk({nm, "_done_low_after_start"}, 32'(bus.done), 32'd0);
        bus.start = 1'b0;
        wait_done(nm, exp_cycles());
    endtask

    task automatic chk_quiet(input string nm);
        chk({nm, "_done"}, 32'(bus.done), 32'd0);
        chk({nm, "_busy"}, 32'(bus.busy), 32'd0);
        chk({nm, "_addr"}, 32'(bus.mem_addr), 32'd0);
        chk({nm, "_wr_en"}, 32'(bus.mem_wr_en), 32'd0);
        chk({nm, "_wr_data"}, 32'(bus.mem_wr_data), 32'd0);
    endtask

    initial begin
        bus.start = 1'b0;
        reset     = 1'b1;
        repeat (3) step();
        chk_quiet("reset");
        reset = 1'b0;
        step();

        // Basic run: every slot 0000000F, done on cycle 385.
        prep(0);
        push_pairs(0, NP - 1);
        launch("basic");
        repeat (8) step();
        chk("done_held", 32'(bus.done), 32'd1);
        chk("no_rerun_busy", 32'(bus.busy), 32'd0);

        // Sign corners plus a zero-operand pair, launched from DONE.
        prep(1);
        push_pairs(0, NP - 1);
        chk("done_before_rerun", 32'(bus.done), 32'd1);
        launch("corners");
        chk("corner0", {dst_mem[DST],    dst_mem[DST+1],  dst_mem[DST+2],  dst_mem[DST+3]},  32'h40000000);
        chk("corner1", {dst_mem[DST+4],  dst_mem[DST+5],  dst_mem[DST+6],  dst_mem[DST+7]},  32'hC0008000);
        chk("corner2", {dst_mem[DST+8],  dst_mem[DST+9],  dst_mem[DST+10], dst_mem[DST+11]}, 32'h00000001);
        chk("corner3", {dst_mem[DST+12], dst_mem[DST+13], dst_mem[DST+14], dst_mem[DST+15]}, 32'h3FFF0001);
        chk("zero_pair", {dst_mem[DST+16], dst_mem[DST+17], dst_mem[DST+18], dst_mem[DST+19]}, 32'h00000000);

        // Random operands with frequent zeros.
        prep(2);
        push_pairs(0, NP - 1);
        launch("random");

        // Abort during MUL of pair 5 (cycle 130), then resume from ARM.
        prep(3);
        for (int i = 0; i < 256; i++) snap[i] = dst_mem[i];
        push_pairs(0, 4);
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        step();
        repeat (129) step();
        chk("abort_busy_in_mul", 32'(bus.busy), 32'd1);
        bus.start = 1'b1;
        step();
        chk("abort_busy", 32'(bus.busy), 32'd0);
        repeat (20) step();
        chk("abort_held_busy", 32'(bus.busy), 32'd0);
        chk("abort_queue_drained", 32'(exp_q.size()), 32'd0);
        for (int i = DST + 20; i < DST + 4*NP; i++) begin
            chk("abort_slot_unchanged", 32'(dst_mem[i]), 32'(snap[i]));
        end
        push_pairs(0, NP - 1);
        bus.start = 1'b0;
        wait_done("abort_resume", exp_cycles());

        // Reset during the second STORE byte of pair 2 (cycle 70).
        prep(3);
        push_pairs(0, 2);
        void'(exp_q.pop_back());
        void'(exp_q.pop_back());
        void'(exp_q.pop_back());
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        step();
        repeat (69) step();
        chk("rst_store_addr", 32'(bus.mem_addr), 32'(DST + 9));
        snap[DST + 9] = dst_mem[DST + 9];
        reset = 1'b1;
        #1;
        chk("rst_cycle_wr_en", 32'(bus.mem_wr_en), 32'd0);
        step();
        chk_quiet("rst_mid");
        chk("rst_no_write", 32'(dst_mem[DST + 9]), 32'(snap[DST + 9]));
        reset = 1'b0;
        repeat (10) step();
        chk("rst_idle_busy", 32'(bus.busy), 32'd0);
        chk("rst_queue_drained", 32'(exp_q.size()), 32'd0);

        // start held high through reset must not arm the controller.
        reset     = 1'b1;
        bus.start = 1'b1;
        repeat (2) step();
        reset     = 1'b0;
        bus.start = 1'b0;
        repeat (10) step();
        chk("start_in_reset_busy", 32'(bus.busy), 32'd0);

        // Fresh run from IDLE after all of the above.
        prep(2);
        push_pairs(0, NP - 1);
        launch("final");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
